ecc_secded_decoder: RTL and testbench



---
 rtl/ecc_secded_decoder.sv | 66 ++++++
 tb/tb_ecc_secded_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_decoder.sv
//============================================================================
// Module      : ecc_secded_decoder
// Description : Extended-Hamming (32,26) SECDED decoder with one register
//               stage: corrects single-bit errors, flags double-bit errors.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ecc_secded_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        err_2_bit
);

    localparam int c_WIDTH = 32;

    logic [4:0]         w_syndrome;
    logic               w_parity;
    logic [c_WIDTH-1:0] w_flip;
    logic [c_WIDTH-1:0] w_data_out_d;
    logic               w_err_2_bit_d;
    logic [c_WIDTH-1:0] r_data_out_q;
    logic               r_err_2_bit_q;

    // XOR of the positions of all set bits equals the Hamming syndrome.
    always_comb begin
        w_syndrome = 5'd0;
        for (int i = 1; i < c_WIDTH; i++) begin
            if (data_in[i]) begin
                w_syndrome = w_syndrome ^ 5'(i);
            end
        end
    end

    assign w_parity = ^data_in;

    // Odd overall parity means a single error at position s (s==0 is bit 0).
    always_comb begin
        w_flip        = '0;
        w_err_2_bit_d = 1'b0;
        if (w_parity) begin
            w_flip[w_syndrome] = 1'b1;
        end else if (w_syndrome != 5'd0) begin
            w_err_2_bit_d = 1'b1;
        end
        w_data_out_d = data_in ^ w_flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out_q  <= '0;
            r_err_2_bit_q <= 1'b0;
        end else begin
            r_data_out_q  <= w_data_out_d;
            r_err_2_bit_q <= w_err_2_bit_d;
        end
    end

    assign data_out  = r_data_out_q;
    assign err_2_bit = r_err_2_bit_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_secded_decoder.sv
//============================================================================
// Module      : tb_ecc_secded_decoder
// Description : Self-checking bench for ecc_secded_decoder against a
//               nearest-codeword reference model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ecc_secded_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        err_2_bit;

    int checks   = 0;
    int failures = 0;

    ecc_secded_decoder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .err_2_bit (err_2_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mask of codeword positions whose index has bit k set.
    function automatic logic [31:0] pos_mask(input int k);
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) begin
            if (((i >> k) & 1) == 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit is_valid(input logic [31:0] w);
        for (int k = 0; k < 5; k++) begin
            if (($countones(w & pos_mask(k)) % 2) != 0) return 1'b0;
        end
        return ($countones(w) % 2) == 0;
    endfunction

    // Turn any word into a valid codeword by fixing check bits then parity.
    function automatic logic [31:0] encode(input logic [31:0] w);
        logic [31:0] c;
        c = w;
        for (int k = 0; k < 5; k++) begin
            if (($countones(c & pos_mask(k)) % 2) != 0) c[1 << k] = ~c[1 << k];
        end
        if (($countones(c) % 2) != 0) c[0] = ~c[0];
        return c;
    endfunction

    // Reference: valid -> unchanged; one flip away from valid -> that codeword;
    // otherwise report a double error and pass the word through.
    task automatic model(input logic [31:0] w, output logic [31:0] d, output logic e);
        d = w;
        e = 1'b0;
        if (!is_valid(w)) begin
            e = 1'b1;
            for (int j = 0; j < 32; j++) begin
                if (e && is_valid(w ^ (32'd1 << j))) begin
                    d = w ^ (32'd1 << j);
                    e = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Continuous compare of DUT outputs against the model every cycle.
    logic [31:0] exp_d;
    logic        exp_e;
    bit          have_exp = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                model(data_in, exp_d, exp_e);
                have_exp = 1'b1;
            end else begin
                have_exp = 1'b0;
            end
            #1;
            if (!rst_n) begin
                check("reset_data", data_out, 32'h0);
                check("reset_err", {31'd0, err_2_bit}, 32'd0);
            end else if (have_exp) begin
                check("model_data", data_out, exp_d);
                check("model_err", {31'd0, err_2_bit}, {31'd0, exp_e});
            end
        end
    end

    task automatic apply(input logic [31:0] w);
        @(negedge clk);
        data_in = w;
    endtask

    task automatic apply_check(input string name, input logic [31:0] w,
                               input logic [31:0] exp_data, input logic exp_err);
        apply(w);
        @(posedge clk);
        #2;
        check({name, "_data"}, data_out, exp_data);
        check({name, "_err"}, {31'd0, err_2_bit}, {31'd0, exp_err});
    endtask

    task automatic model_pin(input string name, input logic [31:0] w,
                             input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d;
        logic        e;
        model(w, d, e);
        check({name, "_mdata"}, d, exp_data);
        check({name, "_merr"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    logic [31:0] cw;
    logic [31:0] cws[8];

    initial begin
        rst_n   = 1'b1;
        data_in = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        check("por_data", data_out, 32'h0);
        check("por_err", {31'd0, err_2_bit}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        model_pin("pin_zero",  32'h00000000, 32'h00000000, 1'b0);
        model_pin("pin_ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        model_pin("pin_bit5",  32'h00000020, 32'h00000000, 1'b0);
        model_pin("pin_bit31", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        model_pin("pin_bit0",  32'h00000001, 32'h00000000, 1'b0);
        model_pin("pin_dbl",   32'h00000028, 32'h00000028, 1'b1);

        apply_check("clean_zero", 32'h00000000, 32'h00000000, 1'b0);
        apply_check("clean_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        apply_check("single_b5",  32'h00000020, 32'h00000000, 1'b0);
        apply_check("single_b31", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        apply_check("single_b0",  32'h00000001, 32'h00000000, 1'b0);
        apply_check("double_3_5", 32'h00000028, 32'h00000028, 1'b1);

        for (int n = 0; n < 8; n++) cws[n] = encode($urandom);

        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 32; j++) begin
                apply_check("sweep_single", cws[n] ^ (32'd1 << j), cws[n], 1'b0);
            end
        end

        for (int n = 0; n < 3; n++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = a + 1; b < 32; b++) begin
                    cw = cws[n] ^ (32'd1 << a) ^ (32'd1 << b);
                    apply_check("sweep_double", cw, cw, 1'b1);
                end
            end
        end

        // Arbitrary words, including 3+ error patterns, back-to-back.
        for (int n = 0; n < 400; n++) apply($urandom);

        // Asynchronous reset mid-stream, between clock edges.
        for (int n = 0; n < 5; n++) apply(encode($urandom) ^ (32'd1 << $urandom_range(31, 0)));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_data", data_out, 32'h0);
        check("async_rst_err", {31'd0, err_2_bit}, 32'd0);
        apply(32'h00000028);
        @(negedge clk);
        rst_n = 1'b1;
        data_in = 32'h7FFFFFFF;
        @(posedge clk);
        #2;
        check("post_rst_data", data_out, 32'hFFFFFFFF);
        check("post_rst_err", {31'd0, err_2_bit}, 32'd0);
        for (int n = 0; n < 50; n++) apply($urandom);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
